// File: rtl/twiddle_addr_gen.sv
// Twiddle-factor ROM address generator for one SDF FFT/IFFT stage.
// Emits (cnt << stride) mod NFFT per enabled cycle, optionally negated for the inverse transform.
module twiddle_addr_gen #(
   parameter int NFFT = 64,
   parameter int AW   = $clog2(NFFT),
   parameter int SW   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          en,
   input  logic          cont,
   input  logic          inverse,
   input  logic [SW-1:0] stride_log2,
   output logic [AW-1:0] addr,
   output logic          addr_valid,
   output logic          frame_last,
   output logic          busy
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [AW-1:0] CNT_LAST = AW'(NFFT - 1);

   state_t        state;
   logic [AW-1:0] cnt;
   logic [SW-1:0] cfg_stride;
   logic          cfg_inv;

   // Shifting within AW bits is the mod-NFFT reduction; strides >= AW shift everything out.
   // Negation in AW bits gives (NFFT - f) mod NFFT, so f = 0 stays 0.
   function automatic logic [AW-1:0] twiddle_addr(input logic [AW-1:0] c,
                                                  input logic [SW-1:0] s,
                                                  input logic          inv);
      logic [AW-1:0] f;
      f = c << s;
      return inv ? (~f + AW'(1)) : f;
   endfunction

   wire at_frame_end = (cnt == CNT_LAST);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
   // the async reset branch clears every register, since nothing here is a memory array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cfg_stride <= '0;
         cfg_inv    <= 1'b0;
         addr       <= '0;
         addr_valid <= 1'b0;
         frame_last <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               addr_valid <= 1'b0;
               frame_last <= 1'b0;
               busy       <= 1'b0;
               if (start && en) begin
                  cfg_stride <= stride_log2;
                  cfg_inv    <= inverse;
                  addr       <= '0;
                  addr_valid <= 1'b1;
                  cnt        <= AW'(1);
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (en) begin
                  addr       <= twiddle_addr(cnt, cfg_stride, cfg_inv);
                  addr_valid <= 1'b1;
                  frame_last <= at_frame_end;
                  cnt        <= cnt + AW'(1);
                  // The final address still uses the old cfg; the new one applies from address 0.
                  if (at_frame_end) begin
                     if (cont || start) begin
                        cfg_stride <= stride_log2;
                        cfg_inv    <= inverse;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end else begin
                  addr_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Randomised scoreboard bench for twiddle_addr_gen (NFFT=64) plus a directed NFFT=16 instance.
module tb_twiddle_addr_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, en, cont, inverse;
   logic [3:0] stride_log2;
   logic [5:0] addr;
   logic       addr_valid, frame_last, busy;

   logic       start16, en16, cont16, inverse16;
   logic [3:0] stride16;
   logic [3:0] addr16;
   logic       valid16, last16, busy16;

   twiddle_addr_gen #(.NFFT(64)) dut (
      .clk(clk), .rst(rst), .start(start), .en(en), .cont(cont), .inverse(inverse),
      .stride_log2(stride_log2), .addr(addr), .addr_valid(addr_valid),
      .frame_last(frame_last), .busy(busy)
   );

   twiddle_addr_gen #(.NFFT(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .en(en16), .cont(cont16), .inverse(inverse16),
      .stride_log2(stride16), .addr(addr16), .addr_valid(valid16),
      .frame_last(last16), .busy(busy16)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      bit last;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp = '{0, 1'b0};
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   in_frame = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: (c * 2^s) mod n, negated mod n for the inverse transform.
   function automatic int model(input int c, input int s, input bit inv, input int n);
      longint f;
      f = (longint'(c) * (longint'(1) << s)) % n;
      if (inv) f = (n - f) % n;
      return int'(f);
   endfunction

   function automatic void push_frame(input int s, input bit inv);
      for (int c = 0; c < 64; c++) sb.push_back('{model(c, s, inv, 64), c == 63});
   endfunction

   // Monitor: pops on every valid address; during an in-frame stall the previous address must hold.
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (addr_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty actual addr=%0d expected no valid address", addr);
            end else begin
               last_exp = sb.pop_front();
               check("addr", int'(addr), last_exp.a);
               check("frame_last", int'(frame_last), int'(last_exp.last));
            end
         end else if (in_frame) begin
            check("stall_addr_hold", int'(addr), last_exp.a);
            check("stall_last_hold", int'(frame_last), int'(last_exp.last));
         end
      end
   end

   task automatic idle_check(input int n, input int exp_addr);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle_valid", int'(addr_valid), 0);
         check("idle_busy", int'(busy), 0);
         check("idle_last", int'(frame_last), 0);
         check("idle_addr", int'(addr), exp_addr);
      end
   endtask

   // nf frames: the first with (s0,i0), chained ones with (s1,i1), which are applied to the
   // inputs right after the start edge so mid-frame changes must not leak into frame 0.
   task automatic run(input int nf, input int s0, input bit i0, input int s1, input bit i1,
                      input int en_pct, input bit by_start);
      int total, done, cyc;
      bit chain;
      total = 64 * nf;
      push_frame(s0, i0);
      for (int f = 1; f < nf; f++) push_frame(s1, i1);
      stride_log2 = 4'(s0);
      inverse = i0;
      start = 1'b1;
      en = 1'b1;
      cont = (nf > 1) && !by_start;
      @(posedge clk); #1;
      check("busy_after_start", int'(busy), 1);
      in_frame = 1'b1;
      stride_log2 = 4'(s1);
      inverse = i1;
      done = 1;
      cyc = 0;
      while (done < total && cyc < 20000) begin
         chain = (done / 64) < (nf - 1);
         cont = chain && !by_start;
         start = chain && by_start;
         en = ($urandom_range(99) < en_pct);
         @(posedge clk); #1;
         if (en) done++;
         cyc++;
      end
      check("frame_timeout", done, total);
      in_frame = 1'b0;
      start = 1'b0;
      cont = 1'b0;
      en = 1'b1;
      check("busy_during_last", int'(busy), 1);
      check("last_presented", int'(frame_last), 1);
      @(posedge clk); #1;
      check("busy_falls", int'(busy), 0);
      check("valid_falls", int'(addr_valid), 0);
      check("last_falls", int'(frame_last), 0);
      check("addr_held_idle", int'(addr), model(63, (nf > 1) ? s1 : s0, (nf > 1) ? i1 : i0, 64));
      en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run16(input int s, input bit inv);
      stride16 = 4'(s);
      inverse16 = inv;
      start16 = 1'b1;
      en16 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         start16 = 1'b0;
         check("n16_valid", int'(valid16), 1);
         check("n16_addr", int'(addr16), model(i, s, inv, 16));
         check("n16_last", int'(last16), int'(i == 15));
      end
      check("n16_busy_last", int'(busy16), 1);
      @(posedge clk); #1;
      check("n16_busy_fall", int'(busy16), 0);
      check("n16_valid_fall", int'(valid16), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      start = 1'b0; en = 1'b0; cont = 1'b0; inverse = 1'b0; stride_log2 = '0;
      start16 = 1'b0; en16 = 1'b0; cont16 = 1'b0; inverse16 = 1'b0; stride16 = '0;
      #2;
      check("rst_addr", int'(addr), 0);
      check("rst_valid", int'(addr_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_last", int'(frame_last), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle_check(5, 0);
      // start with en low must be ignored
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("start_no_en_valid", int'(addr_valid), 0);
      check("start_no_en_busy", int'(busy), 0);
      start = 1'b0;

      mon_en = 1'b1;
      run(1, 0, 1'b0, 5, 1'b1, 100, 1'b0);
      run(1, 2, 1'b0, 0, 1'b0, 100, 1'b0);
      run(1, 0, 1'b1, 0, 1'b0, 100, 1'b0);
      run(1, 1, 1'b0, 0, 1'b0, 50, 1'b0);
      run(2, 0, 1'b0, 3, 1'b0, 100, 1'b0);
      run(2, 1, 1'b1, 7, 1'b0, 60, 1'b1);
      for (int k = 0; k < 6; k++)
         run($urandom_range(1, 3), $urandom_range(0, 15), 1'($urandom_range(1)),
             $urandom_range(0, 15), 1'($urandom_range(1)), $urandom_range(30, 100),
             1'($urandom_range(1)));

      // Abort at cnt=20: reset mid-cycle clears outputs at once, next frame restarts from 0.
      mon_en = 1'b0;
      stride_log2 = 4'd1; inverse = 1'b0; start = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("pre_abort_addr", int'(addr), model(19, 1, 1'b0, 64));
      #1 rst = 1'b0;
      #1;
      check("abort_addr", int'(addr), 0);
      check("abort_valid", int'(addr_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_last", int'(frame_last), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      en = 1'b0;
      idle_check(100, 0);
      mon_en = 1'b1;
      run(1, 0, 1'b0, 0, 1'b0, 70, 1'b0);
      mon_en = 1'b0;

      run16(0, 1'b0);
      run16(2, 1'b1);

      check("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/twiddle_addr_gen.md
# twiddle_addr_gen

Parametrised twiddle-factor address generator for any stage of the N-point SDF FFT/IFFT pipeline. One address is emitted per enabled cycle over a frame of NFFT counts. Address pattern: counter scaled by a run-time power-of-two stride, modulo NFFT. Optional conjugate (inverse-transform) addressing is supported. It sits beside each butterfly stage and drives the twiddle ROM, replacing per-stage fixed generators. It adds stall, back-to-back frames and frame markers.

## Interface
- NFFT, 64, transform length; power of two, 4..4096
- AW, $clog2(NFFT), address/counter width
- SW, 4, width of stride_log2
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a frame (sampled in IDLE, or on the last address of a frame)
- en  input  1  advance enable; 0 = stall
- cont  input  1  continuous mode; chain next frame without idle gap
- inverse  input  1  conjugate addressing for IFFT
- stride_log2  input  SW  address stride exponent for this stage
- addr  output  AW  twiddle ROM address (registered)
- addr_valid  output  1  addr holds a new address this cycle
- frame_last  output  1  addr is the final (NFFT-1th) address of the frame
- busy  output  1  frame in progress

## Operation
- States: IDLE, RUN. Internal: cnt (AW bits), cfg_stride, cfg_inv latched at frame start.
- Address function: f(c) = (c << cfg_stride) mod NFFT. If cfg_inv=1, result is (NFFT - f(c)) mod NFFT.
  - f(0) = 0 in both modes.
  - cfg_stride >= AW gives f = 0 for all c.
- IDLE:
  - busy=0, addr_valid=0, frame_last=0; addr holds its last value.
  - start=1 and en=1: latch stride_log2 and inverse into cfg, then addr<=0, addr_valid<=1, cnt<=1, go RUN.
  - start with en=0 is ignored; start must be held until en=1.
- RUN, en=1:
  - addr<=f(cnt), addr_valid<=1, frame_last<=(cnt==NFFT-1), cnt<=cnt+1 (wraps to 0).
- RUN, en=0:
  - cnt, addr, frame_last hold; addr_valid<=0.
- Frame end: on the enabled edge that emits cnt=NFFT-1:
  - If cont=1 or start=1, stay in RUN, re-latch cfg from inputs, and cnt wraps to 0. The next enabled cycle emits 0 of the new frame with no gap.
  - Otherwise go to IDLE. busy falls on the following cycle, after the last address has been presented.
- start while RUN and not at the frame end: ignored.
- Configuration changes mid-frame have no effect until the next frame start.

## Timing
- Reset (asynchronous, active-low): state=IDLE, cnt=0, cfg=0, addr=0, addr_valid=0, frame_last=0, busy=0. Takes effect immediately and aborts any frame in progress.
- Latency: start sampled at edge E0 (with en=1) gives addr=0 and addr_valid=1 during E0..E1, and busy=1 from E0.
- Throughput: one address per enabled cycle. A frame is exactly NFFT valid addresses, independent of stall pattern.
- frame_last is coincident with the last addr_valid of the frame and stays asserted through any stall that holds that address.
- Back-to-back frames: address NFFT-1 at cycle k is followed by address 0 at cycle k+1 when en stays high.
- Stall: en=0 on an edge means that edge produces no address. addr_valid=0 in the following cycle.

## Test plan
- Reset/idle: assert rst mid-sim, then release with start=0 -> addr=0, addr_valid=0, busy=0, frame_last=0; no outputs toggle for 100 cycles.
- Forward, stride 0, NFFT=64: start pulse with en=1 held -> 64 valid addresses 0,1,...,63 on consecutive cycles; frame_last only on 63; busy drops one cycle later.
- Stride 2, then inverse stride 0 -> sequence 0,4,...,60 repeated 4 times (64 entries). Inverse with stride 0 -> 0,63,62,...,1.
- Stall: random en (~50%) with stride 1 -> exactly 64 valid addresses 0,2,...,62,0,...,62. No duplicates or skips; addr and frame_last hold during stalls.
- Continuous: cont=1 with stride_log2 changed from 0 to 3 mid-frame -> first frame is all stride 0. Second frame starts the cycle after address 63 with 0,8,16,... and no gap.
- Abort/param: rst low at cnt=20 -> outputs clear immediately; next start restarts from 0. Rerun with NFFT=16 -> 16 addresses 0..15 and frame_last on 15.
